// File: rtl/pe_result_drain_if.sv
// pe_result_drain_if: groups the result-stream input, the output-FIFO write
// port and the drop/frame status of pe_result_drain.
//   din / din_v        result word and valid from the last PE (no stall path)
//   fifo_din / _wr_en  write port of the output FIFO
//   fifo_full          output FIFO full flag
//   overflow           sticky "a word was dropped since reset"
//   drop_count         saturating dropped-word count
//   frame_count        completed frames (wraps)
// Modports: slave = the drain block, master = whoever drives the PE side,
// the FIFO flag and observes the status.
interface pe_result_drain_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_v;
  logic [DATA_WIDTH-1:0] fifo_din;
  logic                  fifo_wr_en;
  logic                  fifo_full;
  logic                  overflow;
  logic [15:0]           drop_count;
  logic [23:0]           frame_count;

  modport slave (
    input  din, din_v, fifo_full,
    output fifo_din, fifo_wr_en, overflow, drop_count, frame_count
  );

  modport master (
    output din, din_v, fifo_full,
    input  fifo_din, fifo_wr_en, overflow, drop_count, frame_count
  );
endinterface

// File: rtl/pe_result_drain.sv
// pe_result_drain: receives the un-stallable result stream of the last PE,
// buffers it in a 2**BUF_AW-entry first-word-fall-through elastic buffer and
// writes it into the output FIFO whenever that FIFO is not full. Words that
// arrive with the buffer full (and no pop on the same edge) are dropped and
// counted.
// Optional macro RESULT_TRAILER_EN: after every FRAME_LEN data words a trailer
// {TRAILER_TAG, frame_count} is written (DATA_WIDTH must then be 32). Without
// it the block is a pure buffered pass-through and frame_count reads 0.
// Ports:
//   bus_clk  clock, rising edge
//   rst      asynchronous active-high reset
//   bus      pe_result_drain_if.slave (stream in, FIFO write port, status)
//
// state   | meaning
// DATA    | forwarding buffered data words to the FIFO
// TRAILER | writing the frame trailer word; buffer still accepts input
module pe_result_drain #(
  parameter int         DATA_WIDTH  = 32,
  parameter int         BUF_AW      = 4,
  parameter int         FRAME_LEN   = 64,
  parameter logic [7:0] TRAILER_TAG = 8'hA5
) (
  input  logic            bus_clk,
  input  logic            rst,
  pe_result_drain_if.slave bus
);
  localparam int DEPTH = 2 ** BUF_AW;
  localparam logic [0:0] S_DATA = 1'b0;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [BUF_AW-1:0]     r_wr_ptr;
  logic [BUF_AW-1:0]     r_rd_ptr;
  logic [BUF_AW:0]       r_count;
  logic                  r_overflow;
  logic [15:0]           r_drop_count;

  logic                  w_buf_empty;
  logic                  w_buf_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_dout;
  logic [0:0]            w_state;

  assign w_buf_empty = (r_count == '0);
  assign w_buf_full  = (r_count == (BUF_AW+1)'(DEPTH));

`ifdef RESULT_TRAILER_EN
  localparam logic [0:0] S_TRAILER = 1'b1;
  logic [0:0]  r_state;
  logic [15:0] r_word_cnt;
  logic [23:0] r_frame_count;

  assign w_state = r_state;

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_DATA;
      r_word_cnt    <= '0;
      r_frame_count <= '0;
    end else if (w_wr_en) begin
      if (r_state == S_TRAILER) begin
        r_frame_count <= r_frame_count + 24'd1;
        r_state       <= S_DATA;
      end else if (r_word_cnt == 16'(FRAME_LEN - 1)) begin
        r_word_cnt <= '0;
        r_state    <= S_TRAILER;
      end else begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end
    end
  end

  assign bus.frame_count = r_frame_count;
`else
  // Framing parameters only matter when trailers are built in.
  logic w_unused_cfg;
  assign w_unused_cfg    = ^{TRAILER_TAG, 32'(FRAME_LEN)};
  assign w_state         = S_DATA;
  assign bus.frame_count = '0;
`endif

  // Outputs are forced quiet while rst is high, not just from the next edge.
  always_comb begin
    w_wr_en = 1'b0;
    w_dout  = r_mem[r_rd_ptr];
    w_pop   = 1'b0;
    if (rst) begin
      w_dout = '0;
`ifdef RESULT_TRAILER_EN
    end else if (w_state == S_TRAILER) begin
      w_wr_en = !bus.fifo_full;
      w_dout  = DATA_WIDTH'({TRAILER_TAG, r_frame_count});
`endif
    end else if (w_state == S_DATA) begin
      w_wr_en = !w_buf_empty && !bus.fifo_full;
      w_pop   = w_wr_en;
    end
  end

  // A pop on the same edge frees the slot, so a full buffer can still accept.
  assign w_push = bus.din_v && (!w_buf_full || w_pop);
  assign w_drop = bus.din_v && w_buf_full && !w_pop;

  always_ff @(posedge bus_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.din;
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + BUF_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + BUF_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (BUF_AW+1)'(1);
        2'b01:   r_count <= r_count - (BUF_AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign bus.fifo_wr_en = w_wr_en;
  assign bus.fifo_din   = w_dout;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_pe_result_drain.sv
module tb_pe_result_drain;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int FL = 4;
  localparam int DEPTH = 16;
`ifdef RESULT_TRAILER_EN
  localparam bit TRL = 1'b1;
`else
  localparam bit TRL = 1'b0;
`endif

  logic bus_clk = 1'b0;
  logic rst = 1'b1;

  pe_result_drain_if #(.DATA_WIDTH(DW)) bus ();

  pe_result_drain #(
    .DATA_WIDTH(DW), .BUF_AW(AW), .FRAME_LEN(FL), .TRAILER_TAG(8'hA5)
  ) dut (
    .bus_clk(bus_clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          full;
    bit          e_wr;
    logic [31:0] e_dout;
  } vec_t;

  // Reference model: a queue for the buffer plus frame bookkeeping.
  logic [31:0] m_q[$];
  int          m_in_frame;
  bit          m_trl;
  int          m_frames;
  bit          m_ovf;
  int          m_drops;
  logic [31:0] got[$];
  logic        a_wr;
  logic [31:0] a_dout;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    got.delete();
    m_in_frame = 0;
    m_trl = 1'b0;
    m_frames = 0;
    m_ovf = 1'b0;
    m_drops = 0;
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit full);
    bit          e_wr;
    logic [31:0] e_dout;
    @(negedge bus_clk);
    bus.din_v = v;
    bus.din = d;
    bus.fifo_full = full;
    #1;
    if (TRL && m_trl) begin
      e_wr = !full;
      e_dout = {8'hA5, 24'(m_frames)};
    end else begin
      e_wr = (m_q.size() > 0) && !full;
      e_dout = e_wr ? m_q[0] : 32'h0;
    end
    a_wr = bus.fifo_wr_en;
    a_dout = bus.fifo_din;
    chk("wr_en", 32'(a_wr), 32'(e_wr));
    if (e_wr) chk("fifo_din", a_dout, e_dout);
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("drop_count", 32'(bus.drop_count), 32'(m_drops));
    chk("frame_count", 32'(bus.frame_count), 32'(24'(m_frames)));
    if (a_wr) got.push_back(a_dout);
    if (e_wr) begin
      if (TRL && m_trl) begin
        m_trl = 1'b0;
        m_frames++;
      end else begin
        void'(m_q.pop_front());
        if (TRL) begin
          m_in_frame++;
          if (m_in_frame == FL) begin
            m_in_frame = 0;
            m_trl = 1'b1;
          end
        end
      end
    end
    if (v) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
  endtask

  task automatic do_reset(input bit expect_busy);
    @(negedge bus_clk);
    bus.din_v = 1'b0;
    #1;
    if (expect_busy) chk("pre-rst wr_en", 32'(bus.fifo_wr_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("rst fifo_din", bus.fifo_din, 32'd0);
    chk("rst overflow", 32'(bus.overflow), 32'd0);
    chk("rst drop_count", 32'(bus.drop_count), 32'd0);
    chk("rst frame_count", 32'(bus.frame_count), 32'd0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic check_got(input string name, input logic [31:0] base, input int n, input int frame0);
    logic [31:0] exp[$];
    int k;
    k = frame0;
    for (int i = 0; i < n; i++) begin
      exp.push_back(base + 32'(i));
      if (TRL && (i % FL) == FL - 1) begin
        exp.push_back({8'hA5, 24'(k)});
        k++;
      end
    end
    chk({name, " len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
  endtask

  initial begin
    vec_t tbl[$];
    bus.din_v = 1'b0;
    bus.din = '0;
    bus.fifo_full = 1'b0;
    model_reset();

    #3;
    chk("init wr_en", 32'(bus.fifo_wr_en), 32'd0);
    chk("init fifo_din", bus.fifo_din, 32'd0);
    chk("init overflow", 32'(bus.overflow), 32'd0);
    chk("init drop_count", 32'(bus.drop_count), 32'd0);
    chk("init frame_count", 32'(bus.frame_count), 32'd0);
    @(negedge bus_clk);
    rst = 1'b0;

    // Pass-through latency and a short fifo_full hold.
    for (int i = 0; i < 10; i++) tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1234});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_BEEF});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0});
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].full);
      chk("tbl wr_en", 32'(a_wr), 32'(tbl[i].e_wr));
      if (tbl[i].e_wr) chk("tbl fifo_din", a_dout, tbl[i].e_dout);
    end
    chk("tbl overflow", 32'(bus.overflow), 32'd0);

    // Framing: words 1..8 back to back.
    do_reset(1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
    check_got("frame seq", 32'd1, 8, 0);
    chk("frame_count end", 32'(bus.frame_count), TRL ? 32'd2 : 32'd0);

    // Back-pressure: 16 words held, then drained in order.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 32'd100 + 32'(i), 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("bp drop_count", 32'(bus.drop_count), 32'd0);
    chk("bp no writes", 32'(got.size()), 32'd0);
    for (int i = 0; i < 24; i++) step(1'b0, 32'h0, 1'b0);
    check_got("bp drain", 32'd100, 16, 0);

    // Overflow: 20 words into a 16-deep buffer.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 32'd300 + 32'(i), 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("ovf overflow", 32'(bus.overflow), 32'd1);
    chk("ovf drop_count", 32'(bus.drop_count), 32'd4);
    for (int i = 0; i < 24; i++) step(1'b0, 32'h0, 1'b0);
    check_got("ovf drain", 32'd300, 16, 0);

    // Reset mid-frame with nonzero counters, then a clean frame.
    got.delete();
    step(1'b1, 32'hA1, 1'b0);
    step(1'b1, 32'hA2, 1'b0);
    step(1'b1, 32'hA3, 1'b0);
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h50 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
    check_got("post-rst frame", 32'h50, 4, 0);

    // Push and pop on the same edge with the buffer full.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 32'd200 + 32'(i), 1'b1);
    step(1'b1, 32'd216, 1'b0);
    step(1'b1, 32'd217, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("simul drop_count", 32'(bus.drop_count), 32'd1);
    for (int i = 0; i < 30; i++) step(1'b0, 32'h0, 1'b0);
    check_got("simul drain", 32'd200, 17, 0);

    // Random traffic against the model.
    do_reset(1'b0);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 9) < 8);
    for (int i = 0; i < 40; i++) step(1'b0, 32'h0, 1'b0);
    chk("rand buffer empty", 32'(bus.fifo_wr_en), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
